// File: rtl/alt_ddrx_wdata_defs.sv
// Shared definitions for the write-data read scheduler.
// The read latency here must track the write data FIFO build.
package alt_ddrx_wdata_defs;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } wsched_state_t;

  localparam int DEF_CMDQ_DEPTH      = 4;
  localparam int DEF_FIFO_RD_LATENCY = 2;

endpackage

// File: rtl/alt_ddrx_wdata_cmdq.sv
// Circular command queue holding write burst sizes.
// Pushes when full and pops when empty are ignored.
module alt_ddrx_wdata_cmdq
  import alt_ddrx_wdata_defs::*;
#(
  parameter int DEPTH  = DEF_CMDQ_DEPTH,
  parameter int PTR_W  = 2,
  parameter int DATA_W = 6
) (
  input  logic              ctl_clk,
  input  logic              ctl_reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ctl_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alt_ddrx_wdata_sched.sv
// Write-data read scheduler: waits for a full burst in the
// write FIFO, then reads it back-to-back with aligned strobes.
module alt_ddrx_wdata_sched
  import alt_ddrx_wdata_defs::*;
#(
  parameter int WDATA_BEATS_WIDTH = 9,
  parameter int LOCAL_SIZE_WIDTH  = 6,
  parameter int CMDQ_DEPTH        = DEF_CMDQ_DEPTH,
  parameter int CMDQ_PTR_WIDTH    = 2,
  parameter int FIFO_RD_LATENCY   = DEF_FIFO_RD_LATENCY
) (
  input  logic                         ctl_clk,
  input  logic                         ctl_reset_n,
  input  logic                         wr_cmd_valid,
  input  logic [LOCAL_SIZE_WIDTH-1:0]  wr_cmd_size,
  output logic                         wr_cmd_ready,
  input  logic [WDATA_BEATS_WIDTH-1:0] beats_in_wfifo,
  output logic                         wdata_fifo_read,
  output logic                         wdata_valid,
  output logic                         wdata_last,
  output logic [CMDQ_PTR_WIDTH:0]      cmdq_count,
  output logic                         busy,
  output logic                         underrun_err
);

  localparam logic [LOCAL_SIZE_WIDTH-1:0] ONE = 1;

  wsched_state_t               state, state_nxt;
  logic [LOCAL_SIZE_WIDTH-1:0] rem, rem_nxt;
  logic [LOCAL_SIZE_WIDTH-1:0] head;
  logic                        q_full, q_empty, pop, rd_last;
  logic [FIFO_RD_LATENCY-1:0]  vpipe, lpipe;

  alt_ddrx_wdata_cmdq #(
    .DEPTH  (CMDQ_DEPTH),
    .PTR_W  (CMDQ_PTR_WIDTH),
    .DATA_W (LOCAL_SIZE_WIDTH)
  ) u_cmdq (
    .ctl_clk     (ctl_clk),
    .ctl_reset_n (ctl_reset_n),
    .push        (wr_cmd_valid && wr_cmd_ready),
    .push_data   (wr_cmd_size),
    .pop         (pop),
    .head        (head),
    .count       (cmdq_count),
    .full        (q_full),
    .empty       (q_empty)
  );

  assign wr_cmd_ready = !q_full;

  always_comb begin
    state_nxt       = state;
    rem_nxt         = rem;
    pop             = 1'b0;
    wdata_fifo_read = 1'b0;
    rd_last         = 1'b0;
    unique case (state)
      IDLE: begin
        if (!q_empty) begin
          if (head == '0) begin
            pop = 1'b1;
          end else if (WDATA_BEATS_WIDTH'(head) <= beats_in_wfifo) begin
            pop             = 1'b1;
            wdata_fifo_read = 1'b1;
            rem_nxt         = head - ONE;
            if (head == ONE) rd_last = 1'b1;
            else state_nxt = BURST;
          end
        end
      end
      BURST: begin
        wdata_fifo_read = 1'b1;
        rem_nxt         = rem - ONE;
        if (rem == ONE) begin
          rd_last   = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      state        <= IDLE;
      rem          <= '0;
      vpipe        <= '0;
      lpipe        <= '0;
      underrun_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      rem      <= rem_nxt;
      vpipe[0] <= wdata_fifo_read;
      lpipe[0] <= rd_last;
      for (int i = 1; i < FIFO_RD_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        lpipe[i] <= lpipe[i-1];
      end
      if (wdata_fifo_read && beats_in_wfifo == '0)
        underrun_err <= 1'b1;
    end
  end

  assign wdata_valid = vpipe[FIFO_RD_LATENCY-1];
  assign wdata_last  = lpipe[FIFO_RD_LATENCY-1];
  assign busy        = !q_empty || (state == BURST) || (|vpipe);

endmodule

// File: tb/tb_alt_ddrx_wdata_sched.sv
// Bench for alt_ddrx_wdata_sched: vector table, directed corner
// sequences and random traffic against a queue-based model.
module tb_alt_ddrx_wdata_sched;

  logic       ctl_clk = 1'b0;
  logic       ctl_reset_n;
  logic       wr_cmd_valid;
  logic [5:0] wr_cmd_size;
  logic       wr_cmd_ready;
  logic [8:0] beats_in_wfifo;
  logic       wdata_fifo_read;
  logic       wdata_valid;
  logic       wdata_last;
  logic [2:0] cmdq_count;
  logic       busy;
  logic       underrun_err;

  always #5 ctl_clk = ~ctl_clk;

  alt_ddrx_wdata_sched dut (
    .ctl_clk         (ctl_clk),
    .ctl_reset_n     (ctl_reset_n),
    .wr_cmd_valid    (wr_cmd_valid),
    .wr_cmd_size     (wr_cmd_size),
    .wr_cmd_ready    (wr_cmd_ready),
    .beats_in_wfifo  (beats_in_wfifo),
    .wdata_fifo_read (wdata_fifo_read),
    .wdata_valid     (wdata_valid),
    .wdata_last      (wdata_last),
    .cmdq_count      (cmdq_count),
    .busy            (busy),
    .underrun_err    (underrun_err)
  );

  int checks = 0;
  int errors = 0;

  // model: pending sizes, beats left in the active burst,
  // last two cycles of reads for the strobe delay
  int q[$];
  int cur_rem;
  bit rd_h1, rd_h2, ls_h1, ls_h2;
  bit m_under;
  int fifo_beats;

  int nrd, nlast, cyc, first_rd, last_rd;

  typedef struct {
    bit v; int sz; int beats;
    bit rd; bit val; bit lst; bit rdy; bit bsy;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cur_rem = 0;
    rd_h1 = 0; rd_h2 = 0; ls_h1 = 0; ls_h2 = 0;
    m_under = 0;
    fifo_beats = 0;
  endtask

  task automatic step(input bit v, input int sz, input int add);
    bit e_rd, e_last, e_pop, e_rdy;
    @(negedge ctl_clk);
    fifo_beats += add;
    wr_cmd_valid   = v;
    wr_cmd_size    = 6'(sz);
    beats_in_wfifo = 9'(fifo_beats);
    #1;
    e_rd = 0; e_last = 0; e_pop = 0;
    e_rdy = (q.size() < 4);
    if (cur_rem > 0) begin
      e_rd = 1;
      e_last = (cur_rem == 1);
    end else if (q.size() > 0) begin
      if (q[0] == 0) e_pop = 1;
      else if (q[0] <= fifo_beats) begin
        e_pop = 1; e_rd = 1; e_last = (q[0] == 1);
      end
    end
    chk("ready", wr_cmd_ready, e_rdy);
    chk("count", cmdq_count, q.size());
    chk("rd", wdata_fifo_read, e_rd);
    chk("valid", wdata_valid, rd_h2);
    chk("last", wdata_last, ls_h2);
    chk("busy", busy, (q.size() > 0 || cur_rem > 0 || rd_h1 || rd_h2));
    chk("underrun", underrun_err, m_under);
    if (wdata_fifo_read) begin
      if (nrd == 0) first_rd = cyc;
      last_rd = cyc;
      nrd++;
    end
    if (wdata_last) nlast++;
    if (cur_rem > 0) cur_rem--;
    else if (e_pop) cur_rem = q.pop_front() - (e_rd ? 1 : 0);
    if (v && e_rdy) q.push_back(sz);
    rd_h2 = rd_h1; rd_h1 = e_rd;
    ls_h2 = ls_h1; ls_h1 = e_last;
    if (e_rd && fifo_beats == 0) m_under = 1;
    if (e_rd && fifo_beats > 0) fifo_beats--;
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() > 0 || cur_rem > 0 || rd_h1 || rd_h2) && n < 300) begin
      step(0, 0, (q.size() > 0 && q[0] > fifo_beats) ? q[0] - fifo_beats : 0);
      n++;
    end
    chk("drain_timeout", (n >= 300) ? 1 : 0, 0);
    step(0, 0, 0);
  endtask

  task automatic clr_counts();
    nrd = 0; nlast = 0; first_rd = 0; last_rd = 0;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    clr_counts();
    ctl_reset_n    = 1'b0;
    wr_cmd_valid   = 1'b0;
    wr_cmd_size    = '0;
    beats_in_wfifo = '0;
    repeat (3) @(posedge ctl_clk);
    #1;
    chk("rst_ready", wr_cmd_ready, 1);
    chk("rst_rd", wdata_fifo_read, 0);
    chk("rst_valid", wdata_valid, 0);
    chk("rst_last", wdata_last, 0);
    chk("rst_count", cmdq_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun_err, 0);
    @(negedge ctl_clk);
    ctl_reset_n = 1'b1;

    // size-4 burst, FIFO draining as reads happen
    tbl[0] = '{1, 4, 4, 0, 0, 0, 1, 0};
    tbl[1] = '{0, 0, 4, 1, 0, 0, 1, 1};
    tbl[2] = '{0, 0, 3, 1, 0, 0, 1, 1};
    tbl[3] = '{0, 0, 2, 1, 1, 0, 1, 1};
    tbl[4] = '{0, 0, 1, 1, 1, 0, 1, 1};
    tbl[5] = '{0, 0, 0, 0, 1, 0, 1, 1};
    tbl[6] = '{0, 0, 0, 0, 1, 1, 1, 1};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      @(negedge ctl_clk);
      wr_cmd_valid   = tbl[i].v;
      wr_cmd_size    = 6'(tbl[i].sz);
      beats_in_wfifo = 9'(tbl[i].beats);
      #1;
      chk($sformatf("tbl%0d_rd", i), wdata_fifo_read, tbl[i].rd);
      chk($sformatf("tbl%0d_valid", i), wdata_valid, tbl[i].val);
      chk($sformatf("tbl%0d_last", i), wdata_last, tbl[i].lst);
      chk($sformatf("tbl%0d_ready", i), wr_cmd_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
    end
    fifo_beats = 0;

    // size 8 with 5 beats, topped up to 8 two cycles later
    clr_counts();
    fifo_beats = 5;
    step(1, 8, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t2_no_early_rd", nrd, 0);
    step(0, 0, 3);
    drain();
    chk("t2_reads", nrd, 8);
    chk("t2_contig", last_rd - first_rd + 1, 8);
    chk("t2_lasts", nlast, 1);

    // sizes 3 then 2 with 5 beats: no bubble
    clr_counts();
    fifo_beats = 5;
    step(1, 3, 0);
    step(1, 2, 0);
    drain();
    chk("t3_reads", nrd, 5);
    chk("t3_contig", last_rd - first_rd + 1, 5);
    chk("t3_lasts", nlast, 2);

    // fill the queue without data; fifth push refused during pop
    clr_counts();
    for (int i = 0; i < 4; i++) step(1, 3, 0);
    step(0, 0, 0);
    chk("t4_count_full", cmdq_count, 4);
    chk("t4_ready_low", wr_cmd_ready, 0);
    step(1, 5, 3);
    step(0, 0, 0);
    chk("t4_count_after", cmdq_count, 3);
    drain();
    chk("t4_reads", nrd, 12);

    // size 0 between two size-2 bursts
    clr_counts();
    fifo_beats = 4;
    step(1, 2, 0);
    step(1, 0, 0);
    step(1, 2, 0);
    drain();
    chk("t5_reads", nrd, 4);
    chk("t5_lasts", nlast, 2);

    // reset after 5 reads of a size-16 burst
    clr_counts();
    fifo_beats = 16;
    step(1, 16, 0);
    for (int n = 0; n < 40 && nrd < 5; n++) step(0, 0, 0);
    chk("t6_reads_before_rst", nrd, 5);
    @(negedge ctl_clk);
    ctl_reset_n  = 1'b0;
    wr_cmd_valid = 1'b0;
    @(posedge ctl_clk);
    #1;
    chk("t6_rd", wdata_fifo_read, 0);
    chk("t6_valid", wdata_valid, 0);
    chk("t6_last", wdata_last, 0);
    chk("t6_count", cmdq_count, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", wr_cmd_ready, 1);
    model_reset();
    @(negedge ctl_clk);
    ctl_reset_n = 1'b1;
    clr_counts();
    fifo_beats = 2;
    step(1, 2, 0);
    drain();
    chk("t6_post_reads", nrd, 2);
    chk("t6_post_lasts", nlast, 1);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int add;
      add = (fifo_beats < 300) ? int'($urandom_range(0, 2)) : 0;
      step(($urandom % 3) == 0, int'($urandom_range(0, 9)), add);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
